mips_bus_arbiter: RTL
=====================

// Module: mips_bus_arbiter
// PURPOSE
//   Two-port Avalon-MM bus master that sits between the CPU core and the external memory bus.
//   Shares the single bus between instruction fetch and load/store.
//   Runs each transaction to completion, honouring waitrequest.
//   Returns read data with a one-cycle ack pulse.
// PARAMETERS
//   STARVE_LIMIT    4   max back-to-back data grants while if_req waits; next grant forced to fetch
//   TIMEOUT_CYCLES  0   max cycles in ISSUE before abort; 0 = timeout disabled
// PORTS
//   clk          in   1   system clock, all state on rising edge
//   reset        in   1   asynchronous, active-low reset (0 = reset)
//   if_req       in   1   fetch request, level; held with if_addr until if_ack
//   if_addr      in   32  fetch word address
//   if_rdata     out  32  fetched word, valid while if_ack=1
//   if_ack       out  1   one-cycle completion pulse for fetch
//   d_req        in   1   data request, level; held with d_* until d_ack
//   d_we         in   1   1 = write, 0 = read
//   d_addr       in   32  data address
//   d_wdata      in   32  store data
//   d_be         in   4   store/load byte enables
//   d_rdata      out  32  load data, valid while d_ack=1
//   d_ack        out  1   one-cycle completion pulse for data
//   address      out  32  Avalon address
//   read         out  1   Avalon read strobe
//   write        out  1   Avalon write strobe
//   writedata    out  32  Avalon write data
//   byteenable   out  4   Avalon byte enables
//   waitrequest  in   1   Avalon stall; transfer completes in a cycle with strobe=1, waitrequest=0
//   readdata     in   32  Avalon read data, sampled at completion
//   busy         out  1   1 whenever state != IDLE
//   timeout_err  out  1   sticky; set on any timeout abort, cleared only by reset
// BEHAVIOUR
//   Reset: all outputs 0; state=IDLE; grant and timeout counters 0. Asynchronous, so reset
//     mid-transaction drops the strobes at once and loses any pending ack.
//   States: IDLE -> ISSUE -> ACK -> IDLE. All outputs are registered.
//   IDLE: sample if_req/d_req.
//     - Neither set: stay in IDLE.
//     - Otherwise grant, latch the granted port's addr/we/wdata/be, and go to ISSUE.
//   Arbitration: data wins over fetch, except when the starve counter equals STARVE_LIMIT
//     and if_req=1; then fetch wins.
//     - Starve counter increments on each data grant made while if_req=1.
//     - It clears on any fetch grant and whenever if_req=0 in IDLE.
//   ISSUE: drive address plus read or write from the latched values.
//     - Fetch: byteenable=4'hF, write=0.
//     - Data read: writedata=0.
//     - All bus outputs stay stable while waitrequest=1.
//     - On waitrequest=0: capture readdata (reads) into the granted port's rdata register,
//       drop the strobes, go to ACK.
//   ACK: pulse the granted port's ack for exactly one cycle; rdata is valid in the same cycle.
//     - Writes give rdata=0.
//     - Next state is IDLE.
//     - Requester drops req on the edge that ends the ack cycle unless it wants another access.
//   Latency: req seen at edge k -> strobe high in cycle k+1 -> ack in cycle k+2+N, where N is
//     the number of waitrequest=1 cycles. Minimum request-to-request spacing is 3 cycles.
//   Only one ack is ever high in a cycle; never both ports.
//   Timeout (TIMEOUT_CYCLES>0): a counter counts ISSUE cycles and clears on entry to ISSUE.
//     - If it reaches TIMEOUT_CYCLES with waitrequest still 1: drop the strobes, set rdata
//       to 32'hFFFF_FFFF, set timeout_err, go to ACK.
//   Request changes while in ISSUE/ACK are ignored; only the latched copy drives the bus.
//   d_we=1 with d_be=4'h0 is issued as-is (a write that touches no bytes).
//   Simultaneous reset deassert and req: req is first sampled on the first edge with reset=1.
// TESTING
//   1. Fetch only, waitrequest=0, readdata=32'h2402_0005, if_addr=32'hBFC0_0000
//      -> read=1, address=BFC0_0000 for 1 cycle; if_ack=1 two cycles after req;
//         if_rdata=32'h2402_0005.
//   2. Data write with waitrequest=1 for 3 cycles, d_addr=32'h1000, d_wdata=32'hDEAD_BEEF,
//      d_be=4'h3
//      -> write=1 and bus outputs stable for 4 cycles; d_ack 1 cycle later; read never 1.
//   3. if_req and d_req both held high continuously, STARVE_LIMIT=4
//      -> grant order D,D,D,D,F,D,D,D,D,F; never two acks in one cycle.
//   4. TIMEOUT_CYCLES=8, waitrequest stuck at 1 on a data read
//      -> strobe drops after 8 cycles; d_ack with d_rdata=FFFF_FFFF; timeout_err=1 until reset.
//   5. reset asserted during ISSUE with waitrequest=1
//      -> read/write/ack go 0 immediately; busy=0; after release the same held req is re-issued.
//   6. Data read, byteenable=4'h1, readdata=32'h0000_00A5
//      -> d_rdata=32'h0000_00A5; writedata=0 throughout.

Source files
------------

// File: rtl/mips_bus_arbiter.sv
// mips_bus_arbiter
//   Avalon-MM bus master shared between the CPU's instruction-fetch port and
//   its load/store port. One transaction is in flight at a time. Each one runs
//   to completion (honouring waitrequest) and finishes with a one-cycle ack
//   pulse on the port that was granted.
//
// Parameters
//   STARVE_LIMIT    data grants allowed back-to-back while a fetch waits
//   TIMEOUT_CYCLES  ISSUE cycles before a stalled transfer is aborted (0 = off)
//
// Ports
//   clk, reset                   clock; asynchronous active-low reset
//   if_req/if_addr               fetch request (level) and word address
//   if_rdata/if_ack              fetched word and its one-cycle completion pulse
//   d_req/d_we/d_addr/d_wdata/d_be   load/store request and its attributes
//   d_rdata/d_ack                load data and its one-cycle completion pulse
//   address/read/write/writedata/byteenable   Avalon master outputs
//   waitrequest/readdata         Avalon slave stall and read data
//   busy                         high whenever a transaction is in progress
//   timeout_err                  sticky abort flag, cleared only by reset

module mips_bus_arbiter #(
  parameter int unsigned STARVE_LIMIT   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  output logic        busy,
  output logic        timeout_err
);

  localparam int unsigned SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam int unsigned TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    ACK   = 2'd2
  } state_t;

  state_t          state;
  logic            grant_data;
  logic [SW-1:0]   starve_cnt;
  logic [TW-1:0]   timeout_cnt;

  logic            fetch_starved;
  logic            timeout_hit;

  // The counter never passes the limit: once it reaches it with a fetch pending,
  // the fetch wins and the counter clears.
  assign fetch_starved = if_req && (starve_cnt == SW'(STARVE_LIMIT));

  // The counter runs 0..TIMEOUT_CYCLES-1. The last stalled ISSUE cycle is the
  // one in which the count has reached TIMEOUT_CYCLES-1.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) &&
                       (timeout_cnt == TW'(TIMEOUT_CYCLES - 1));

  // Single controller.
  // The bus outputs hold the latched copy of the granted request. Later
  // changes on the request ports cannot disturb a transfer once it has
  // started. The bus outputs return to zero when the strobe drops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      grant_data  <= 1'b0;
      starve_cnt  <= '0;
      timeout_cnt <= '0;
      if_rdata    <= 32'h0;
      if_ack      <= 1'b0;
      d_rdata     <= 32'h0;
      d_ack       <= 1'b0;
      address     <= 32'h0;
      read        <= 1'b0;
      write       <= 1'b0;
      writedata   <= 32'h0;
      byteenable  <= 4'h0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if_ack <= 1'b0;
      d_ack  <= 1'b0;

      case (state)
        IDLE: begin
          if (d_req && !fetch_starved) begin
            grant_data  <= 1'b1;
            address     <= d_addr;
            read        <= !d_we;
            write       <= d_we;
            writedata   <= d_we ? d_wdata : 32'h0;
            byteenable  <= d_be;
            starve_cnt  <= if_req ? (starve_cnt + SW'(1)) : '0;
            timeout_cnt <= '0;
            busy        <= 1'b1;
            state       <= ISSUE;
          end else if (if_req) begin
            grant_data  <= 1'b0;
            address     <= if_addr;
            read        <= 1'b1;
            write       <= 1'b0;
            writedata   <= 32'h0;
            byteenable  <= 4'hF;
            starve_cnt  <= '0;
            timeout_cnt <= '0;
            busy        <= 1'b1;
            state       <= ISSUE;
          end else begin
            starve_cnt  <= '0;
          end
        end

        ISSUE: begin
          if (!waitrequest || timeout_hit) begin
            // On an abort the granted port receives all-ones in place of data.
            if (grant_data) begin
              d_ack   <= 1'b1;
              d_rdata <= !waitrequest ? (read ? readdata : 32'h0) : 32'hFFFF_FFFF;
            end else begin
              if_ack   <= 1'b1;
              if_rdata <= !waitrequest ? readdata : 32'hFFFF_FFFF;
            end
            if (waitrequest) begin
              timeout_err <= 1'b1;
            end
            address    <= 32'h0;
            read       <= 1'b0;
            write      <= 1'b0;
            writedata  <= 32'h0;
            byteenable <= 4'h0;
            state      <= ACK;
          end else begin
            timeout_cnt <= timeout_cnt + TW'(1);
          end
        end

        ACK: begin
          if_rdata <= 32'h0;
          d_rdata  <= 32'h0;
          busy     <= 1'b0;
          state    <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
